// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: shares the GRF write port between W-stage writeback (priority) and a queued aux requester,
// tracking pending aux destinations in a busy scoreboard and bubbling the pipe when the queue starves.
module grf_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  input  logic [31:0] pipe_pc,
  input  logic        aux_req,
  input  logic [4:0]  aux_addr,
  input  logic [31:0] aux_data,
  input  logic [31:0] aux_pc,
  output logic        aux_ack,
  input  logic        resv_valid,
  input  logic [4:0]  resv_addr,
  output logic [31:0] busy,
  output logic        full,
  output logic        stall_req,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT) + 1;
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;
  ent_t          mem_q [DEPTH];
  ent_t          head;
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;
  logic [31:0]   busy_q, busy_d, set_mask, clr_mask;
  logic          grf_we_q, grf_we_d;
  logic [4:0]    grf_a3_q, grf_a3_d;
  logic [31:0]   grf_wd_q, grf_wd_d, grf_pc_q, grf_pc_d;
  logic          pipe_sel, empty, pop, push, stall_hit;
  assign head      = mem_q[head_q];
  assign empty     = count_q == '0;
  assign full      = count_q == CW'(DEPTH);
  assign pipe_sel  = pipe_we & (pipe_addr != 5'd0);
  assign pop       = ~pipe_sel & ~empty;
  assign aux_ack   = aux_req & ~full;
  assign push      = aux_ack & (aux_addr != 5'd0);
  assign count_d   = count_q + CW'(push) - CW'(pop);
  assign stall_hit = ~empty & ~pop & (starve_q == SW'(STARVE_LIMIT - 1));
  // counter restarts after each stall pulse so a lost bubble is re-requested STARVE_LIMIT cycles later
  assign starve_d  = (empty | pop | stall_hit) ? '0 : starve_q + 1'b1;
  assign stall_d   = stall_hit;
  assign set_mask  = resv_valid ? 32'd1 << resv_addr : '0;
  assign clr_mask  = pop ? 32'd1 << head.addr : '0;
  assign busy_d    = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
  always_comb begin
    grf_we_d = pipe_sel | pop;
    grf_a3_d = pipe_sel ? pipe_addr : pop ? head.addr : grf_a3_q;
    grf_wd_d = pipe_sel ? pipe_data : pop ? head.data : grf_wd_q;
    grf_pc_d = pipe_sel ? pipe_pc   : pop ? head.pc   : grf_pc_q;
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= {aux_addr, aux_data, aux_pc};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      busy_q   <= '0;
      grf_we_q <= 1'b0;
      grf_a3_q <= '0;
      grf_wd_q <= '0;
      grf_pc_q <= '0;
    end else begin
      head_q   <= pop  ? head_q + 1'b1 : head_q;
      tail_q   <= push ? tail_q + 1'b1 : tail_q;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      busy_q   <= busy_d;
      grf_we_q <= grf_we_d;
      grf_a3_q <= grf_a3_d;
      grf_wd_q <= grf_wd_d;
      grf_pc_q <= grf_pc_d;
    end
  end
  assign busy      = busy_q;
  assign stall_req = stall_q;
  assign grf_we    = grf_we_q;
  assign grf_a3    = grf_a3_q;
  assign grf_wd    = grf_wd_q;
  assign grf_pc    = grf_pc_q;
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb_grf_wb_arbiter: directed checks of GRF write-port arbitration, aux queue, scoreboard and starvation bubble.
module tb_grf_wb_arbiter;
  logic        clk = 1'b0, reset = 1'b0;
  logic        pipe_we, aux_req, resv_valid;
  logic [4:0]  pipe_addr, aux_addr, resv_addr;
  logic [31:0] pipe_data, pipe_pc, aux_data, aux_pc;
  logic        aux_ack, full, stall_req, grf_we;
  logic [31:0] busy, grf_wd, grf_pc;
  logic [4:0]  grf_a3;
  int          n_tests = 0, n_fail = 0;
  grf_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_pc(pipe_pc),
    .aux_req(aux_req), .aux_addr(aux_addr), .aux_data(aux_data), .aux_pc(aux_pc), .aux_ack(aux_ack),
    .resv_valid(resv_valid), .resv_addr(resv_addr), .busy(busy), .full(full), .stall_req(stall_req),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    pipe_we = 0; pipe_addr = 0; pipe_data = 0; pipe_pc = 0;
    aux_req = 0; aux_addr = 0; aux_data = 0; aux_pc = 0;
    resv_valid = 0; resv_addr = 0;
  endtask
  task automatic pipe(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    pipe_we = 1; pipe_addr = a; pipe_data = d; pipe_pc = p;
  endtask
  task automatic aux(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    aux_req = 1; aux_addr = a; aux_data = d; aux_pc = p;
  endtask
  initial begin
    idle();
    cyc(); cyc();
    chk("rst_we", grf_we, 0);
    chk("rst_a3", grf_a3, 0);
    chk("rst_wd", grf_wd, 0);
    chk("rst_pc", grf_pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_stall", stall_req, 0);
    reset = 1;
    cyc();
    // pipe only
    pipe(5, 32'h1234_5678, 32'h3000);
    cyc();
    chk("pipe_we", grf_we, 1);
    chk("pipe_a3", grf_a3, 5);
    chk("pipe_wd", grf_wd, 32'h1234_5678);
    chk("pipe_pc", grf_pc, 32'h3000);
    pipe(0, 32'hDEAD_BEEF, 32'h3004);
    cyc();
    chk("pipe_a0_we", grf_we, 0);
    chk("pipe_a0_hold_a3", grf_a3, 5);
    chk("pipe_a0_hold_wd", grf_wd, 32'h1234_5678);
    idle();
    // aux with idle pipe
    resv_valid = 1; resv_addr = 8;
    cyc();
    resv_valid = 0;
    chk("resv8_busy", busy, 32'h100);
    aux(8, 32'hA5A5_0000, 32'h4000);
    #1 chk("aux8_ack", aux_ack, 1);
    cyc();
    aux_req = 0;
    chk("aux8_pushed_busy", busy, 32'h100);
    chk("aux8_no_bypass", grf_we, 0);
    cyc();
    chk("aux8_we", grf_we, 1);
    chk("aux8_a3", grf_a3, 8);
    chk("aux8_wd", grf_wd, 32'hA5A5_0000);
    chk("aux8_pc", grf_pc, 32'h4000);
    chk("aux8_busy_clr", busy, 0);
    cyc();
    chk("aux8_done", grf_we, 0);
    // full and wrap
    pipe(1, 32'h11, 32'h5000);
    aux(10, 32'hA0, 32'h6000);
    #1 chk("full_ack0", aux_ack, 1);
    cyc();
    aux(11, 32'hB0, 32'h6004);
    #1 chk("full_ack1", aux_ack, 1);
    cyc();
    chk("full_set", full, 1);
    aux(12, 32'hC0, 32'h6008);
    #1 chk("full_ack2", aux_ack, 0);
    cyc();
    chk("full_pipe_a3", grf_a3, 1);
    chk("full_still", full, 1);
    idle();
    cyc();
    chk("drain0_a3", grf_a3, 10);
    chk("drain0_wd", grf_wd, 32'hA0);
    chk("drain0_full", full, 0);
    cyc();
    chk("drain1_a3", grf_a3, 11);
    chk("drain1_pc", grf_pc, 32'h6004);
    aux(13, 32'h100, 32'h7000);
    cyc();
    for (int k = 1; k <= 6; k++) begin
      aux(5'(13 + k), 32'h100 + 32'(k), 32'h7000 + 32'(4 * k));
      #1 chk("wrap_ack", aux_ack, 1);
      cyc();
      chk("wrap_we", grf_we, 1);
      chk("wrap_a3", grf_a3, 32'(13 + k - 1));
      chk("wrap_wd", grf_wd, 32'h100 + 32'(k - 1));
    end
    idle();
    cyc();
    chk("wrap_last_a3", grf_a3, 19);
    chk("wrap_last_pc", grf_pc, 32'h7018);
    cyc();
    chk("wrap_empty_we", grf_we, 0);
    // starvation, bubble taken
    pipe(1, 32'h22, 32'h8000);
    aux(20, 32'hC0, 32'h9000);
    cyc();
    aux_req = 0;
    for (int i = 1; i <= 4; i++) begin
      chk("starve_wait", stall_req, 0);
      cyc();
    end
    chk("starve_pulse", stall_req, 1);
    pipe_we = 0;
    cyc();
    chk("starve_pop_a3", grf_a3, 20);
    chk("starve_pop_wd", grf_wd, 32'hC0);
    chk("starve_pulse_end", stall_req, 0);
    // starvation, bubble ignored
    pipe(1, 32'h33, 32'h8100);
    aux(21, 32'hD0, 32'h9100);
    cyc();
    aux_req = 0;
    for (int i = 1; i <= 4; i++) cyc();
    chk("restarve_pulse1", stall_req, 1);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("restarve_gap", stall_req, 0);
    end
    cyc();
    chk("restarve_pulse2", stall_req, 1);
    chk("restarve_pipe_a3", grf_a3, 1);
    pipe_we = 0;
    cyc();
    chk("restarve_pop_a3", grf_a3, 21);
    idle();
    cyc();
    // scoreboard conflict
    resv_valid = 1; resv_addr = 9;
    cyc();
    resv_valid = 0;
    aux(9, 32'hE0, 32'hA000);
    cyc();
    aux_req = 0;
    resv_valid = 1; resv_addr = 9;
    cyc();
    chk("conflict_a3", grf_a3, 9);
    chk("conflict_busy", busy, 32'h200);
    resv_addr = 0;
    cyc();
    chk("resv0_busy", busy, 32'h200);
    idle();
    // reset mid-stream
    pipe(1, 32'h44, 32'hB000);
    resv_valid = 1; resv_addr = 4; aux(4, 32'h40, 32'hC000);
    cyc();
    resv_addr = 5; aux(5, 32'h50, 32'hC004);
    cyc();
    resv_valid = 0; aux_req = 0;
    chk("mid_busy", busy, 32'h230);
    chk("mid_full", full, 1);
    chk("mid_we", grf_we, 1);
    #2 reset = 0;
    #1;
    chk("async_we", grf_we, 0);
    chk("async_full", full, 0);
    chk("async_busy", busy, 0);
    cyc();
    idle();
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("post_rst_we", grf_we, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
